// File: rtl/timer_pkg.sv
// Shared constants for the APB timer family: direction encoding, default
// counter width and the status-register bit layout.
package timer_pkg;

  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

  localparam int CNT_WIDTH_DEF = 8;

  // Bit positions in the timer status register (shared with the APB block).
  typedef enum logic [1:0] {
    ST_OVF     = 2'd0,
    ST_UNF     = 2'd1,
    ST_OVR_OVF = 2'd2,
    ST_OVR_UNF = 2'd3
  } status_idx_e;

endpackage

// File: rtl/timer_flag_cell.sv
// Sticky write-1-to-clear status flag with overrun tracking. A new event
// always wins over a simultaneous clear; overrun records an event that
// landed on an already-set, unacknowledged flag.
module timer_flag_cell (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic hit_i,
  input  logic clr_i,
  output logic flag_o,
  output logic ovr_o
);

  logic flag_q, flag_d;
  logic ovr_q,  ovr_d;

  // Next state: set on hit, hold until cleared; overrun only without a clear.
  always_comb begin
    flag_d = hit_i | (flag_q & ~clr_i);
    ovr_d  = (hit_i & flag_q & ~clr_i) | (ovr_q & ~clr_i);
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      flag_q <= 1'b0;
      ovr_q  <= 1'b0;
    end else begin
      flag_q <= flag_d;
      ovr_q  <= ovr_d;
    end
  end

  assign flag_o = flag_q;
  assign ovr_o  = ovr_q;

endmodule

// File: rtl/timer_status_gen.sv
// Timer wrap-event detector feeding sticky W1C status flags (or the legacy
// level compare) and an enable-masked interrupt.
module timer_status_gen
  import timer_pkg::*;
#(
  parameter int CNT_WIDTH = CNT_WIDTH_DEF,
  parameter bit STICKY    = 1'b1,
  parameter bit IRQ_REG   = 1'b1
) (
  input  logic                 PCLK,
  input  logic                 PRESETn,
  input  logic                 Up_Down,
  input  logic                 cnt_en,
  input  logic [CNT_WIDTH-1:0] TCNT,
  input  logic                 clr_ovf,
  input  logic                 clr_unf,
  input  logic                 ie_ovf,
  input  logic                 ie_unf,
  output logic                 evt_ovf,
  output logic                 evt_unf,
  output logic                 s_tmr_ovf,
  output logic                 s_tmr_unf,
  output logic                 ovr_ovf,
  output logic                 ovr_unf,
  output logic                 irq
);

  if (CNT_WIDTH < 2) begin : g_bad_width
    $error("timer_status_gen: CNT_WIDTH must be >= 2");
  end

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  logic at_max, at_min, ovf_hit, unf_hit;
  logic evt_ovf_q, evt_unf_q;
  logic irq_src;

  assign at_max  = (TCNT == CNT_MAX);
  assign at_min  = (TCNT == '0);
  // A wrap only counts when the counter actually advances this edge.
  assign ovf_hit = cnt_en & (Up_Down == DIR_UP)   & at_max;
  assign unf_hit = cnt_en & (Up_Down == DIR_DOWN) & at_min;

  // One-cycle event pulses, registered copies of the hits.
  always_ff @(posedge PCLK) begin
    if (!PRESETn) begin
      evt_ovf_q <= 1'b0;
      evt_unf_q <= 1'b0;
    end else begin
      evt_ovf_q <= ovf_hit;
      evt_unf_q <= unf_hit;
    end
  end

  assign evt_ovf = evt_ovf_q;
  assign evt_unf = evt_unf_q;

  if (STICKY) begin : g_sticky
    timer_flag_cell u_ovf (
      .clk_i (PCLK),
      .rst_ni(PRESETn),
      .hit_i (ovf_hit),
      .clr_i (clr_ovf),
      .flag_o(s_tmr_ovf),
      .ovr_o (ovr_ovf)
    );
    timer_flag_cell u_unf (
      .clk_i (PCLK),
      .rst_ni(PRESETn),
      .hit_i (unf_hit),
      .clr_i (clr_unf),
      .flag_o(s_tmr_unf),
      .ovr_o (ovr_unf)
    );
  end else begin : g_legacy
    logic lvl_ovf_q, lvl_unf_q;

    // Legacy level compare: registered every cycle regardless of cnt_en.
    always_ff @(posedge PCLK) begin
      if (!PRESETn) begin
        lvl_ovf_q <= 1'b0;
        lvl_unf_q <= 1'b0;
      end else begin
        lvl_ovf_q <= at_max & (Up_Down == DIR_UP);
        lvl_unf_q <= at_min & (Up_Down == DIR_DOWN);
      end
    end

    assign s_tmr_ovf = lvl_ovf_q;
    assign s_tmr_unf = lvl_unf_q;
    assign ovr_ovf   = 1'b0;
    assign ovr_unf   = 1'b0;
  end

  assign irq_src = (s_tmr_ovf & ie_ovf) | (s_tmr_unf & ie_unf);

  if (IRQ_REG) begin : g_irq_reg
    logic irq_q;

    // Registered interrupt: one cycle behind flag or enable changes.
    always_ff @(posedge PCLK) begin
      if (!PRESETn) irq_q <= 1'b0;
      else          irq_q <= irq_src;
    end

    assign irq = irq_q;
  end else begin : g_irq_comb
    assign irq = irq_src;
  end

endmodule

// File: tb/tb_timer_status_gen.sv
// Scoreboard bench for timer_status_gen: three instances (8-bit sticky with
// registered irq, 8-bit legacy with combinational irq, 16-bit sticky with
// combinational irq) share stimulus; a reference model predicts every
// output vector {evt_ovf,evt_unf,s_ovf,s_unf,ovr_ovf,ovr_unf,irq}.
module tb_timer_status_gen;

  logic PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  logic        PRESETn, Up_Down, cnt_en, clr_ovf, clr_unf, ie_ovf, ie_unf;
  logic [7:0]  TCNT;
  logic [15:0] TCNT_W;
  wire  [6:0]  oa, ob, oc;

  timer_status_gen #(.CNT_WIDTH(8), .STICKY(1'b1), .IRQ_REG(1'b1)) u_a (
    .PCLK(PCLK), .PRESETn(PRESETn), .Up_Down(Up_Down), .cnt_en(cnt_en),
    .TCNT(TCNT), .clr_ovf(clr_ovf), .clr_unf(clr_unf),
    .ie_ovf(ie_ovf), .ie_unf(ie_unf),
    .evt_ovf(oa[6]), .evt_unf(oa[5]), .s_tmr_ovf(oa[4]), .s_tmr_unf(oa[3]),
    .ovr_ovf(oa[2]), .ovr_unf(oa[1]), .irq(oa[0]));

  timer_status_gen #(.CNT_WIDTH(8), .STICKY(1'b0), .IRQ_REG(1'b0)) u_b (
    .PCLK(PCLK), .PRESETn(PRESETn), .Up_Down(Up_Down), .cnt_en(cnt_en),
    .TCNT(TCNT), .clr_ovf(clr_ovf), .clr_unf(clr_unf),
    .ie_ovf(ie_ovf), .ie_unf(ie_unf),
    .evt_ovf(ob[6]), .evt_unf(ob[5]), .s_tmr_ovf(ob[4]), .s_tmr_unf(ob[3]),
    .ovr_ovf(ob[2]), .ovr_unf(ob[1]), .irq(ob[0]));

  timer_status_gen #(.CNT_WIDTH(16), .STICKY(1'b1), .IRQ_REG(1'b0)) u_c (
    .PCLK(PCLK), .PRESETn(PRESETn), .Up_Down(Up_Down), .cnt_en(cnt_en),
    .TCNT(TCNT_W), .clr_ovf(clr_ovf), .clr_unf(clr_unf),
    .ie_ovf(ie_ovf), .ie_unf(ie_unf),
    .evt_ovf(oc[6]), .evt_unf(oc[5]), .s_tmr_ovf(oc[4]), .s_tmr_unf(oc[3]),
    .ovr_ovf(oc[2]), .ovr_unf(oc[1]), .irq(oc[0]));

  typedef struct packed {
    logic [6:0] a;
    logic [6:0] b;
    logic [6:0] c;
  } exp_t;

  exp_t q[$];
  int   n_vec = 0;
  int   n_err = 0;

  // Reference state: what each instance should show after the last edge.
  bit a_so, a_su, a_oo, a_ou, a_irq, a_eo, a_eu;
  bit b_so, b_su, b_irq;
  bit c_so, c_su, c_oo, c_ou, c_eo, c_eu, c_irq;

  task automatic chk(input string name, input logic [6:0] act, input logic [6:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s t=%0t actual=%b expected=%b", name, $time, act, exp);
    end
  endtask

  // Sticky-flag rule from the event point of view: a new event always
  // (re)marks the flag; a clear with no new event acknowledges it; an event
  // on a still-unacknowledged flag is an overrun, which only a clear removes.
  task automatic sticky(input bit hit, input bit clr, inout bit s, inout bit o);
    bit overrun_now;
    overrun_now = hit && s && !clr;
    if (clr)              o = 0;
    if (overrun_now)      o = 1;
    if (hit)              s = 1;
    else if (clr)         s = 0;
  endtask

  task automatic drive(input bit rst_n, input bit dir, input bit en,
                       input logic [7:0] t, input logic [15:0] tw,
                       input bit co, input bit cu, input bit io, input bit iu,
                       input bit pre_chk);
    bit ho, hu, hwo, hwu, old_irq_src;
    exp_t e;
    @(negedge PCLK);
    PRESETn = rst_n; Up_Down = dir; cnt_en = en; TCNT = t; TCNT_W = tw;
    clr_ovf = co; clr_unf = cu; ie_ovf = io; ie_unf = iu;
    if (pre_chk) begin
      #1;
      chk("sync_reset_no_edge", oa, {a_eo, a_eu, a_so, a_su, a_oo, a_ou, a_irq});
    end
    ho  = en && !dir && (t == 8'd255);
    hu  = en &&  dir && (t == 8'd0);
    hwo = en && !dir && (tw == 16'd65535);
    hwu = en &&  dir && (tw == 16'd0);
    if (!rst_n) begin
      {a_so, a_su, a_oo, a_ou, a_irq, a_eo, a_eu} = '0;
      {b_so, b_su, b_irq} = '0;
      {c_so, c_su, c_oo, c_ou, c_eo, c_eu, c_irq} = '0;
    end else begin
      old_irq_src = (a_so && io) || (a_su && iu);
      a_irq = old_irq_src;
      a_eo = ho; a_eu = hu;
      sticky(ho, co, a_so, a_oo);
      sticky(hu, cu, a_su, a_ou);
      b_so = (t == 8'd255) && !dir;
      b_su = (t == 8'd0) && dir;
      b_irq = (b_so && io) || (b_su && iu);
      c_eo = hwo; c_eu = hwu;
      sticky(hwo, co, c_so, c_oo);
      sticky(hwu, cu, c_su, c_ou);
      c_irq = (c_so && io) || (c_su && iu);
    end
    e.a = {a_eo, a_eu, a_so, a_su, a_oo, a_ou, a_irq};
    e.b = {a_eo, a_eu, b_so, b_su, 1'b0, 1'b0, b_irq};
    e.c = {c_eo, c_eu, c_so, c_su, c_oo, c_ou, c_irq};
    q.push_back(e);
  endtask

  task automatic idle(input bit dir, input logic [7:0] t, input bit io, input bit iu);
    drive(1, dir, 0, t, 16'h1234, 0, 0, io, iu, 0);
  endtask

  function automatic logic [7:0] pick8();
    logic [7:0] v;
    case ($urandom_range(0, 3))
      0: v = 8'h00;
      1: v = 8'hFF;
      2: v = ($urandom_range(0, 1) != 0) ? 8'hFE : 8'h01;
      default: v = 8'($urandom);
    endcase
    return v;
  endfunction

  function automatic logic [15:0] pick16();
    logic [15:0] v;
    case ($urandom_range(0, 3))
      0: v = 16'h0000;
      1: v = 16'hFFFF;
      2: v = 16'h00FF;
      default: v = 16'($urandom);
    endcase
    return v;
  endfunction

  // Monitor: outputs are valid every cycle, checked just after each edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge PCLK);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("sticky8_regirq", oa, e.a);
        chk("legacy8_combirq", ob, e.b);
        chk("sticky16_combirq", oc, e.c);
      end
    end
  end

  initial begin
    PRESETn = 0; Up_Down = 0; cnt_en = 0; TCNT = 0; TCNT_W = 0;
    clr_ovf = 0; clr_unf = 0; ie_ovf = 0; ie_unf = 0;
    drive(0, 0, 0, 8'h00, 16'h0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 8'h00, 16'h0, 0, 0, 0, 0, 0);

    // Up wrap with overflow interrupt enabled.
    drive(1, 0, 1, 8'hFE, 16'h1, 0, 0, 1, 0, 0);
    drive(1, 0, 1, 8'hFF, 16'h1, 0, 0, 1, 0, 0);
    repeat (3) idle(0, 8'h10, 1, 0);

    // Reset mid-run while s_tmr_ovf is set.
    drive(0, 0, 0, 8'h10, 16'h1, 0, 0, 1, 0, 1);
    idle(0, 8'h10, 1, 0);

    // Gating: sitting at zero counting down without a tick is not an event.
    repeat (10) drive(1, 1, 0, 8'h00, 16'h0, 0, 0, 0, 1, 0);
    drive(1, 1, 1, 8'h00, 16'h0, 0, 0, 0, 1, 0);
    repeat (2) idle(1, 8'h05, 0, 1);

    // W1C and overrun.
    drive(1, 0, 1, 8'hFF, 16'hFFFF, 0, 0, 1, 0, 0);
    drive(1, 0, 1, 8'hFF, 16'hFFFF, 0, 0, 1, 0, 0);
    idle(0, 8'h20, 1, 0);
    drive(1, 0, 0, 8'h20, 16'h1, 1, 0, 1, 0, 0);
    idle(0, 8'h20, 1, 0);
    drive(1, 0, 1, 8'hFF, 16'h1, 0, 0, 1, 0, 0);
    drive(1, 0, 1, 8'hFF, 16'h1, 1, 0, 1, 0, 0);
    repeat (2) idle(0, 8'h20, 1, 0);
    drive(1, 0, 0, 8'h20, 16'h1, 1, 1, 0, 0, 0);

    // Legacy level: held at all-ones without ticks, clears ignored.
    repeat (3) drive(1, 0, 0, 8'hFF, 16'hFFFF, 1, 0, 1, 0, 0);
    drive(1, 0, 0, 8'h7F, 16'h1, 0, 0, 1, 0, 0);

    // 16-bit compare width.
    drive(1, 0, 1, 8'h10, 16'hFFFF, 0, 0, 1, 0, 0);
    drive(1, 0, 1, 8'h10, 16'h00FF, 0, 0, 1, 0, 0);
    drive(1, 0, 1, 8'h10, 16'h00FF, 1, 0, 1, 0, 0);

    // Randomized traffic biased toward the wrap limits.
    for (int i = 0; i < 600; i++) begin
      drive(($urandom_range(0, 49) != 0), 1'($urandom), ($urandom_range(0, 9) < 7),
            pick8(), pick16(),
            ($urandom_range(0, 4) == 0), ($urandom_range(0, 4) == 0),
            1'($urandom), 1'($urandom), 0);
    end

    repeat (3) @(posedge PCLK);
    #2;
    if (q.size() != 0) begin
      n_vec++;
      n_err++;
      $display("FAIL scoreboard_drain pending=%0d required=0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
